// File: rtl/msdap_input_ctrl.sv
// MSDAP front-end loader: streams Rj values, coefficients and then samples into the ALU memories.
// Runs one ALU pass per sample and stalls input until alu_done; a run of zero samples enters sleep.
module msdap_input_ctrl #(
  parameter int ZERO_RUN = 800,
  parameter int ZCNT_W   = 10
) (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        reload_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_word_i,
  output logic        rj_we_o,
  output logic [3:0]  rj_waddr_o,
  output logic [7:0]  rj_wdata_o,
  output logic        coeff_we_o,
  output logic [8:0]  coeff_waddr_o,
  output logic [15:0] coeff_wdata_o,
  output logic        data_we_o,
  output logic [7:0]  data_waddr_o,
  output logic [15:0] data_wdata_o,
  output logic [7:0]  current_data_addr_o,
  output logic        alu_enable_o,
  output logic        alu_clear_o,
  input  logic        alu_done_i,
  output logic        sleep_o
);

  localparam logic [2:0] S_LOAD_RJ    = 3'd0;
  localparam logic [2:0] S_LOAD_COEFF = 3'd1;
  localparam logic [2:0] S_WAIT_DATA  = 3'd2;
  localparam logic [2:0] S_WORKING    = 3'd3;
  localparam logic [2:0] S_SLEEP      = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [3:0]        rj_cnt_q, rj_cnt_d;
  logic [8:0]        coeff_cnt_q, coeff_cnt_d;
  logic [7:0]        data_ptr_q, data_ptr_d;
  logic [ZCNT_W-1:0] zcnt_q, zcnt_d;
  logic              in_ready_q, in_ready_d;
  logic              pend_q, pend_d;
  logic              alu_enable_q, alu_enable_d;
  logic              alu_clear_q, alu_clear_d;
  logic              sleep_q, sleep_d;
  logic              rj_we_q, rj_we_d;
  logic [3:0]        rj_waddr_q, rj_waddr_d;
  logic [7:0]        rj_wdata_q, rj_wdata_d;
  logic              coeff_we_q, coeff_we_d;
  logic [8:0]        coeff_waddr_q, coeff_waddr_d;
  logic [15:0]       coeff_wdata_q, coeff_wdata_d;
  logic              data_we_q, data_we_d;
  logic [7:0]        data_waddr_q, data_waddr_d;
  logic [15:0]       data_wdata_q, data_wdata_d;
  logic [7:0]        cur_addr_q, cur_addr_d;

  logic accept;
  logic start_pass;
  logic is_zero;

  assign accept  = in_valid_i && in_ready_q;
  assign is_zero = (in_word_i == 16'h0000);

  always_comb begin
    state_d       = state_q;
    rj_cnt_d      = rj_cnt_q;
    coeff_cnt_d   = coeff_cnt_q;
    data_ptr_d    = data_ptr_q;
    zcnt_d        = zcnt_q;
    pend_d        = pend_q;
    alu_enable_d  = alu_enable_q;
    sleep_d       = sleep_q;
    rj_we_d       = 1'b0;
    rj_waddr_d    = rj_waddr_q;
    rj_wdata_d    = rj_wdata_q;
    coeff_we_d    = 1'b0;
    coeff_waddr_d = coeff_waddr_q;
    coeff_wdata_d = coeff_wdata_q;
    data_we_d     = 1'b0;
    data_waddr_d  = data_waddr_q;
    data_wdata_d  = data_wdata_q;
    cur_addr_d    = cur_addr_q;
    start_pass    = 1'b0;
    in_ready_d    = 1'b0;
    alu_clear_d   = 1'b1;

    if (reload_i) begin
      // Restart from Rj load; memories keep their contents.
      state_d      = S_LOAD_RJ;
      rj_cnt_d     = 4'd0;
      coeff_cnt_d  = 9'd0;
      data_ptr_d   = 8'd0;
      zcnt_d       = '0;
      pend_d       = 1'b0;
      alu_enable_d = 1'b0;
      sleep_d      = 1'b0;
      cur_addr_d   = 8'd0;
    end else begin
      if (alu_enable_q && alu_done_i) alu_enable_d = 1'b0;
      // The write lands one cycle before the ALU is enabled.
      if (pend_q) begin
        pend_d       = 1'b0;
        alu_enable_d = 1'b1;
      end

      if (accept) begin
        case (state_q)
          S_LOAD_RJ: begin
            rj_we_d    = 1'b1;
            rj_waddr_d = rj_cnt_q;
            rj_wdata_d = in_word_i[7:0];
            if (rj_cnt_q == 4'd15) begin
              rj_cnt_d = 4'd0;
              state_d  = S_LOAD_COEFF;
            end else begin
              rj_cnt_d = rj_cnt_q + 4'd1;
            end
          end
          S_LOAD_COEFF: begin
            coeff_we_d    = 1'b1;
            coeff_waddr_d = coeff_cnt_q;
            coeff_wdata_d = in_word_i;
            if (coeff_cnt_q == 9'd511) begin
              coeff_cnt_d = 9'd0;
              state_d     = S_WAIT_DATA;
            end else begin
              coeff_cnt_d = coeff_cnt_q + 9'd1;
            end
          end
          S_WAIT_DATA, S_WORKING, S_SLEEP: begin
            data_we_d    = 1'b1;
            data_waddr_d = data_ptr_q;
            data_wdata_d = in_word_i;
            cur_addr_d   = data_ptr_q;
            data_ptr_d   = data_ptr_q + 8'd1;
            if (!is_zero) begin
              zcnt_d     = '0;
              start_pass = 1'b1;
              sleep_d    = 1'b0;
              state_d    = S_WORKING;
            end else if (state_q != S_SLEEP) begin
              if (zcnt_q + ZCNT_W'(1) == ZCNT_W'(ZERO_RUN)) begin
                zcnt_d  = ZCNT_W'(ZERO_RUN);
                sleep_d = 1'b1;
                state_d = S_SLEEP;
              end else begin
                zcnt_d     = zcnt_q + ZCNT_W'(1);
                start_pass = 1'b1;
                state_d    = S_WORKING;
              end
            end
          end
          default: state_d = S_LOAD_RJ;
        endcase
      end

      if (start_pass) pend_d = 1'b1;
      in_ready_d  = !start_pass && !pend_q && !(alu_enable_q && !alu_done_i);
      alu_clear_d = (state_d == S_LOAD_RJ) || (state_d == S_LOAD_COEFF) ||
                    (state_d == S_WAIT_DATA);
    end
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q       <= S_LOAD_RJ;
      rj_cnt_q      <= 4'd0;
      coeff_cnt_q   <= 9'd0;
      data_ptr_q    <= 8'd0;
      zcnt_q        <= '0;
      in_ready_q    <= 1'b0;
      pend_q        <= 1'b0;
      alu_enable_q  <= 1'b0;
      alu_clear_q   <= 1'b1;
      sleep_q       <= 1'b0;
      rj_we_q       <= 1'b0;
      rj_waddr_q    <= 4'd0;
      rj_wdata_q    <= 8'd0;
      coeff_we_q    <= 1'b0;
      coeff_waddr_q <= 9'd0;
      coeff_wdata_q <= 16'd0;
      data_we_q     <= 1'b0;
      data_waddr_q  <= 8'd0;
      data_wdata_q  <= 16'd0;
      cur_addr_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      rj_cnt_q      <= rj_cnt_d;
      coeff_cnt_q   <= coeff_cnt_d;
      data_ptr_q    <= data_ptr_d;
      zcnt_q        <= zcnt_d;
      in_ready_q    <= in_ready_d;
      pend_q        <= pend_d;
      alu_enable_q  <= alu_enable_d;
      alu_clear_q   <= alu_clear_d;
      sleep_q       <= sleep_d;
      rj_we_q       <= rj_we_d;
      rj_waddr_q    <= rj_waddr_d;
      rj_wdata_q    <= rj_wdata_d;
      coeff_we_q    <= coeff_we_d;
      coeff_waddr_q <= coeff_waddr_d;
      coeff_wdata_q <= coeff_wdata_d;
      data_we_q     <= data_we_d;
      data_waddr_q  <= data_waddr_d;
      data_wdata_q  <= data_wdata_d;
      cur_addr_q    <= cur_addr_d;
    end
  end

  assign in_ready_o          = in_ready_q;
  assign rj_we_o             = rj_we_q;
  assign rj_waddr_o          = rj_waddr_q;
  assign rj_wdata_o          = rj_wdata_q;
  assign coeff_we_o          = coeff_we_q;
  assign coeff_waddr_o       = coeff_waddr_q;
  assign coeff_wdata_o       = coeff_wdata_q;
  assign data_we_o           = data_we_q;
  assign data_waddr_o        = data_waddr_q;
  assign data_wdata_o        = data_wdata_q;
  assign current_data_addr_o = cur_addr_q;
  assign alu_enable_o        = alu_enable_q;
  assign alu_clear_o         = alu_clear_q;
  assign sleep_o             = sleep_q;

endmodule

// File: tb/tb_msdap_input_ctrl.sv
// Directed bench for msdap_input_ctrl with a short zero run so sleep is reachable quickly.
module tb_msdap_input_ctrl;

  logic        clk;
  logic        clear;
  logic        reload;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        rj_we;
  logic [3:0]  rj_waddr;
  logic [7:0]  rj_wdata;
  logic        coeff_we;
  logic [8:0]  coeff_waddr;
  logic [15:0] coeff_wdata;
  logic        data_we;
  logic [7:0]  data_waddr;
  logic [15:0] data_wdata;
  logic [7:0]  cur_addr;
  logic        alu_enable;
  logic        alu_clear;
  logic        alu_done;
  logic        sleep;

  int checks = 0;
  int errors = 0;

  msdap_input_ctrl #(.ZERO_RUN(4), .ZCNT_W(3)) dut (
    .clk_i(clk), .clear_i(clear), .reload_i(reload),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_word_i(in_word),
    .rj_we_o(rj_we), .rj_waddr_o(rj_waddr), .rj_wdata_o(rj_wdata),
    .coeff_we_o(coeff_we), .coeff_waddr_o(coeff_waddr), .coeff_wdata_o(coeff_wdata),
    .data_we_o(data_we), .data_waddr_o(data_waddr), .data_wdata_o(data_wdata),
    .current_data_addr_o(cur_addr), .alu_enable_o(alu_enable), .alu_clear_o(alu_clear),
    .alu_done_i(alu_done), .sleep_o(sleep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word and returns in the cycle after the edge that accepted it.
  task automatic send_word(input logic [15:0] w);
    int t;
    in_valid = 1'b1;
    in_word  = w;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk("ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_config();
    for (int k = 0; k < 16; k++) begin
      send_word(16'h0A00 + 16'(k));
      chk("rj_we", rj_we, 1);
      chk("rj_waddr", rj_waddr, k);
      chk("rj_wdata", rj_wdata, k);
      chk("rj_clear", alu_clear, 1);
      chk("rj_no_data", data_we, 0);
    end
    for (int k = 0; k < 512; k++) begin
      send_word(16'h1000 + 16'(k));
      chk("cf_we", coeff_we, 1);
      chk("cf_waddr", coeff_waddr, k);
      chk("cf_wdata", coeff_wdata, 32'h1000 + k);
      chk("cf_clear", alu_clear, 1);
      chk("cf_no_data", data_we, 0);
    end
  endtask

  task automatic send_sample(input logic [15:0] w, input int addr, input bit pass, input bit slp);
    send_word(w);
    chk("d_we", data_we, 1);
    chk("d_waddr", data_waddr, addr);
    chk("d_wdata", data_wdata, w);
    chk("cur_addr", cur_addr, addr);
    chk("d_clear", alu_clear, 0);
    chk("d_sleep", sleep, slp);
    if (pass) begin
      chk("rdy_busy", in_ready, 0);
      chk("en_early", alu_enable, 0);
      tick();
      chk("en_on", alu_enable, 1);
      chk("d_we_off", data_we, 0);
      repeat (2) tick();
      chk("rdy_hold", in_ready, 0);
      chk("en_hold", alu_enable, 1);
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      chk("en_off", alu_enable, 0);
      chk("rdy_back", in_ready, 1);
    end else begin
      chk("rdy_nopass", in_ready, 1);
      tick();
      chk("en_nopass", alu_enable, 0);
    end
  endtask

  initial begin
    clear = 1'b1; reload = 1'b0; in_valid = 1'b0; in_word = 16'h0; alu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_clear", alu_clear, 1);
    chk("rst_enable", alu_enable, 0);
    chk("rst_sleep", sleep, 0);
    chk("rst_rj_we", rj_we, 0);
    chk("rst_cur", cur_addr, 0);
    clear = 1'b0;
    tick();
    chk("ready_rise", in_ready, 1);
    chk("clear_hold", alu_clear, 1);

    load_config();

    // first sample, then circular buffer wrap
    send_sample(16'h1234, 0, 1'b1, 1'b0);
    for (int j = 1; j <= 257; j++)
      send_sample(16'h2000 + 16'(j), j % 256, 1'b1, 1'b0);

    // sleep entry and wake with ZERO_RUN = 4
    send_sample(16'h0005, 2, 1'b1, 1'b0);
    send_sample(16'h0000, 3, 1'b1, 1'b0);
    send_sample(16'h0000, 4, 1'b1, 1'b0);
    send_sample(16'h0000, 5, 1'b1, 1'b0);
    send_sample(16'h0000, 6, 1'b0, 1'b1);
    send_sample(16'h0000, 7, 1'b0, 1'b1);
    send_sample(16'h0007, 8, 1'b1, 1'b0);

    // reload mid-pass with simultaneous beat and alu_done
    send_word(16'h0009);
    chk("rl_waddr", data_waddr, 9);
    tick();
    chk("rl_en_on", alu_enable, 1);
    reload = 1'b1; in_valid = 1'b1; in_word = 16'hBEEF; alu_done = 1'b1;
    tick();
    reload = 1'b0; in_valid = 1'b0; alu_done = 1'b0;
    chk("rl_en_off", alu_enable, 0);
    chk("rl_clear", alu_clear, 1);
    chk("rl_ready_low", in_ready, 0);
    chk("rl_no_dwe", data_we, 0);
    chk("rl_no_rjwe", rj_we, 0);
    chk("rl_sleep", sleep, 0);
    tick();
    chk("rl_ready_up", in_ready, 1);
    send_word(16'h0A55);
    chk("rl_rj_we", rj_we, 1);
    chk("rl_rj_addr", rj_waddr, 0);
    chk("rl_rj_data", rj_wdata, 8'h55);

    // async clear during coefficient load
    for (int k = 1; k < 16; k++) send_word(16'h0A00 + 16'(k));
    for (int k = 0; k < 10; k++) send_word(16'h1000 + 16'(k));
    chk("pre_clr_cf", coeff_waddr, 9);
    in_valid = 1'b1; in_word = 16'h1111;
    #2;
    clear = 1'b1;
    #1;
    chk("aclr_ready", in_ready, 0);
    chk("aclr_clear", alu_clear, 1);
    chk("aclr_cf_we", coeff_we, 0);
    chk("aclr_cf_addr", coeff_waddr, 0);
    chk("aclr_enable", alu_enable, 0);
    in_valid = 1'b0;
    tick();
    clear = 1'b0;
    tick();
    chk("aclr_ready_up", in_ready, 1);
    load_config();
    send_sample(16'h4321, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
